// File: rtl/spi_master.sv
// SPI mode-0 master. Each accepted start runs one full-duplex WIDTH-bit transfer, MSB first.
// The sclk half-period is HALFDIV clk cycles.
module spi_master #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned HALFDIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] txData,
    output logic             ready,
    output logic [WIDTH-1:0] rxData,
    output logic             done,
    output logic             sclk,
    output logic             cs_n,
    output logic             mosi,
    input  logic             miso
);
    localparam int unsigned    CW      = $clog2(HALFDIV) + 1;
    localparam int unsigned    BW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  HC_LAST = CW'(HALFDIV - 1);
    localparam logic [BW-1:0]  BITS    = BW'(WIDTH);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, TRAIL} state_e;

    state_e           state_q,  state_d;
    logic [CW-1:0]    hcnt_q,   hcnt_d;
    logic [BW-1:0]    bcnt_q,   bcnt_d;
    logic [WIDTH-1:0] tx_q,     tx_d;
    logic [WIDTH-1:0] rx_q,     rx_d;
    logic [WIDTH-1:0] rxdata_q, rxdata_d;
    logic             done_q,   done_d;
    logic             ready_q,  ready_d;
    logic             sclk_q,   sclk_d;
    logic             cs_n_q,   cs_n_d;
    logic             mosi_q,   mosi_d;

    logic             hc_last;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;

    assign hc_last  = (hcnt_q == HC_LAST);
    assign tx_shift = tx_q << 1;
    assign rx_shift = (rx_q << 1) | WIDTH'(miso);

    // Next-state and output decode; every non-idle state lasts exactly HALFDIV clks
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        bcnt_d   = bcnt_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rxdata_d = rxdata_q;
        done_d   = 1'b0;
        ready_d  = ready_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        mosi_d   = mosi_q;

        // Half-period counter restarts on every state change
        if (state_q != IDLE) begin
            hcnt_d = hc_last ? '0 : hcnt_q + CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d    = txData;
                    mosi_d  = txData[WIDTH-1];
                    cs_n_d  = 1'b0;
                    ready_d = 1'b0;
                    bcnt_d  = '0;
                    state_d = SETUP;
                end
            end
            SETUP, LOW: begin
                // sclk rising edge: sample miso and count the bit
                if (hc_last) begin
                    sclk_d  = 1'b1;
                    rx_d    = rx_shift;
                    bcnt_d  = bcnt_q + BW'(1);
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (hc_last) begin
                    sclk_d = 1'b0;
                    if (bcnt_q < BITS) begin
                        tx_d    = tx_shift;
                        mosi_d  = tx_shift[WIDTH-1];
                        state_d = LOW;
                    end else begin
                        state_d = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (hc_last) begin
                    cs_n_d   = 1'b1;
                    rxdata_d = rx_q;
                    done_d   = 1'b1;
                    ready_d  = 1'b1;
                    mosi_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            bcnt_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rxdata_q <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            bcnt_q   <= bcnt_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rxdata_q <= rxdata_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            mosi_q   <= mosi_d;
        end
    end

    assign ready  = ready_q;
    assign rxData = rxdata_q;
    assign done   = done_q;
    assign sclk   = sclk_q;
    assign cs_n   = cs_n_q;
    assign mosi   = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (HALFDIV=2 and HALFDIV=1).
// Outputs are compared every cycle against a transfer-timeline model.
module tb_spi_master;
    localparam int W  = 8;
    localparam int NI = 2;
    localparam int HD     [NI] = '{2, 1};
    localparam int LIT_CS [NI] = '{34, 17};

    logic clk = 1'b0;
    logic rst_n;

    logic [NI-1:0]        start_a;
    logic [NI-1:0][W-1:0] txd_a;
    logic [NI-1:0]        ready_a, done_a, sclk_a, cs_a, mosi_a, miso_a;
    logic [NI-1:0][W-1:0] rx_a;
    logic [NI-1:0]        loop_a, rnd_a, mconst_a, mrand_a;

    int           lit_arm [NI];
    logic [W-1:0] lit_tx  [NI];
    logic [W-1:0] lit_rx  [NI];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign miso_a = (loop_a & mosi_a) | (~loop_a & mrand_a);

    spi_master #(.WIDTH(W), .HALFDIV(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .txData(txd_a[0]),
        .ready(ready_a[0]), .rxData(rx_a[0]), .done(done_a[0]),
        .sclk(sclk_a[0]), .cs_n(cs_a[0]), .mosi(mosi_a[0]), .miso(miso_a[0])
    );

    spi_master #(.WIDTH(W), .HALFDIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .txData(txd_a[1]),
        .ready(ready_a[1]), .rxData(rx_a[1]), .done(done_a[1]),
        .sclk(sclk_a[1]), .cs_n(cs_a[1]), .mosi(mosi_a[1]), .miso(miso_a[1])
    );

    // p = clk cycles since the start was accepted; sclk is high in every other half-period after setup
    function automatic bit exp_sclk(input int h, input int p);
        return (p >= h) && (p < 2*W*h) && (((p - h) / h) % 2 == 0);
    endfunction

    function automatic bit is_rise(input int h, input int p);
        return (p >= h) && (p < 2*W*h) && ((p - h) % (2*h) == 0);
    endfunction

    // Model state
    logic         m_busy [NI];
    int           m_p    [NI];
    logic [W-1:0] m_tx   [NI];
    logic [W-1:0] m_acc  [NI];
    logic [W-1:0] m_rx   [NI];
    logic         m_done [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_busy[i] = 1'b0; m_p[i] = 0; m_tx[i] = '0;
            m_acc[i] = '0; m_rx[i] = '0; m_done[i] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < NI; i++) begin
                if (!rst_n) begin
                    m_busy[i] = 1'b0; m_p[i] = 0; m_tx[i] = '0;
                    m_acc[i] = '0; m_rx[i] = '0; m_done[i] = 1'b0;
                end else begin
                    m_done[i] = 1'b0;
                    if (m_busy[i]) begin
                        if (is_rise(HD[i], m_p[i] + 1))
                            m_acc[i] = {m_acc[i][W-2:0], miso_a[i]};
                        if (m_p[i] + 1 == (2*W + 1) * HD[i]) begin
                            m_busy[i] = 1'b0;
                            m_rx[i]   = m_acc[i];
                            m_done[i] = 1'b1;
                        end else begin
                            m_p[i] = m_p[i] + 1;
                        end
                    end else if (start_a[i]) begin
                        m_busy[i] = 1'b1;
                        m_p[i]    = 0;
                        m_tx[i]   = txd_a[i];
                        m_acc[i]  = '0;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s[inst%0d] @%0t: got %0h, expected %0h", nm, i, $time, act, exp_v);
        end
    endtask

    // Per-cycle compare, plus literal per-transfer measurements
    int           cs_len   [NI];
    int           rises    [NI];
    int           hi_len   [NI];
    int           lit_used [NI];
    logic         prev_sclk[NI];
    logic [W-1:0] mosi_seq [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            cs_len[i] = 0; rises[i] = 0; hi_len[i] = 0; lit_used[i] = 0;
            prev_sclk[i] = 1'b0; mosi_seq[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk("rxData", i, 32'(rx_a[i]), 32'(m_rx[i]));
                if (m_busy[i]) begin
                    chk("cs_n", i, 32'(cs_a[i]), 0);
                    chk("ready", i, 32'(ready_a[i]), 0);
                    chk("done", i, 32'(done_a[i]), 0);
                    chk("sclk", i, 32'(sclk_a[i]), 32'(exp_sclk(HD[i], m_p[i])));
                    if (m_p[i] < 2*W*HD[i])
                        chk("mosi", i, 32'(mosi_a[i]), 32'(m_tx[i][W-1 - m_p[i]/(2*HD[i])]));
                end else begin
                    chk("cs_n", i, 32'(cs_a[i]), 1);
                    chk("ready", i, 32'(ready_a[i]), 1);
                    chk("done", i, 32'(done_a[i]), 32'(m_done[i]));
                    chk("sclk", i, 32'(sclk_a[i]), 0);
                    chk("mosi", i, 32'(mosi_a[i]), 0);
                end

                if (!rst_n) begin
                    cs_len[i] = 0; rises[i] = 0; hi_len[i] = 0;
                end else begin
                    if (sclk_a[i] && !prev_sclk[i]) begin
                        rises[i]++;
                        mosi_seq[i] = {mosi_seq[i][W-2:0], mosi_a[i]};
                    end
                    if (sclk_a[i]) begin
                        hi_len[i]++;
                    end else begin
                        if (prev_sclk[i]) chk("sclk_high_clks", i, 32'(hi_len[i]), 32'(HD[i]));
                        hi_len[i] = 0;
                    end
                    if (cs_a[i]) begin
                        if (done_a[i] && lit_arm[i] != lit_used[i]) begin
                            chk("cs_low_clks", i, 32'(cs_len[i]), 32'(LIT_CS[i]));
                            chk("sclk_rises", i, 32'(rises[i]), 8);
                            chk("mosi_at_rises", i, 32'(mosi_seq[i]), 32'(lit_tx[i]));
                            chk("rx_literal", i, 32'(rx_a[i]), 32'(lit_rx[i]));
                            lit_used[i] = lit_arm[i];
                        end
                        cs_len[i] = 0;
                        rises[i]  = 0;
                    end else begin
                        cs_len[i]++;
                    end
                end
                prev_sclk[i] = sclk_a[i];
            end
        end
    end

    // Random miso source, refreshed just after each rising edge
    initial begin
        mrand_a = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++)
                mrand_a[i] = rnd_a[i] ? 1'($urandom) : mconst_a[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int i, input logic [W-1:0] tx, input bit arm, input logic [W-1:0] erx);
        if (arm) begin
            lit_tx[i] = tx;
            lit_rx[i] = erx;
            lit_arm[i]++;
        end
        start_a[i] = 1'b1;
        txd_a[i]   = tx;
        tick();
        start_a[i] = 1'b0;
        txd_a[i]   = W'($urandom);
    endtask

    initial begin
        rst_n    = 1'b0;
        start_a  = '0;
        txd_a    = '0;
        loop_a   = '1;
        rnd_a    = '0;
        mconst_a = '0;
        for (int i = 0; i < NI; i++) begin
            lit_arm[i] = 0; lit_tx[i] = '0; lit_rx[i] = '0;
        end
        repeat (3) tick();

        // Start presented together with reset release: accepted on the first edge
        rst_n = 1'b1;
        xfer(0, 8'hA5, 1'b1, 8'hA5);
        repeat (36) tick();

        // miso held high, all-zero word out
        loop_a[0] = 1'b0; mconst_a[0] = 1'b1;
        tick();
        xfer(0, 8'h00, 1'b1, 8'hFF);
        repeat (36) tick();
        loop_a[0] = 1'b1; mconst_a[0] = 1'b0;

        // start held high across the whole transfer, txData changed midway
        lit_tx[0] = 8'h3C; lit_rx[0] = 8'h3C; lit_arm[0]++;
        start_a[0] = 1'b1; txd_a[0] = 8'h3C;
        repeat (15) tick();
        txd_a[0] = 8'hFF;
        repeat (21) tick();
        start_a[0] = 1'b0;
        repeat (36) tick();

        // Reset right after the 4th sclk rise, then a clean transfer
        xfer(0, 8'hC3, 1'b0, 8'h00);
        repeat (14) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        xfer(0, 8'h81, 1'b1, 8'h81);
        repeat (36) tick();

        // HALFDIV=1 loopback
        xfer(1, 8'h5A, 1'b1, 8'h5A);
        repeat (19) tick();

        // Random words, random miso, random gaps including back-to-back starts
        loop_a = '0;
        rnd_a  = '1;
        for (int k = 0; k < 30; k++) begin
            int inst;
            inst = int'($urandom_range(0, NI - 1));
            xfer(inst, W'($urandom), 1'b0, 8'h00);
            repeat ((2*W + 1) * HD[inst] + int'($urandom_range(0, 3))) tick();
        end
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: WIDTH, default 8, bits per transfer.
REQ-002 Parameter: HALFDIV, default 4, clk cycles per SCLK half-period; legal range is 1 or greater.
REQ-003 Port: clk  in  1  system clock; all state changes on its rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: start  in  1  transfer request, sampled each clk.
REQ-006 Port: txData  in  WIDTH  word to send; captured when a start is accepted.
REQ-007 Port: ready  out  1  high when idle; a start is accepted only while ready=1.
REQ-008 Port: rxData  out  WIDTH  last received word; holds until the next done.
REQ-009 Port: done  out  1  one-clk pulse at the end of a transfer.
REQ-010 Port: sclk  out  1  SPI serial clock, idle low.
REQ-011 Port: cs_n  out  1  chip select, active low.
REQ-012 Port: mosi  out  1  serial data out, MSB first.
REQ-013 Port: miso  in  1  serial data in, MSB first.

Function
REQ-014 The block SHALL implement SPI mode 0 (CPOL=0, CPHA=0): data is sampled on the sclk rising edge, and mosi changes only while sclk is low.
REQ-015 States SHALL be IDLE, SETUP, HIGH, LOW, TRAIL.
REQ-016 IDLE: ready=1, cs_n=1, sclk=0, mosi=0. If start=1, the next clk SHALL:
- capture txData into the tx shift register;
- drive mosi=txData[WIDTH-1];
- drive cs_n=0 and ready=0;
- clear the bit counter;
- enter SETUP.
REQ-017 SETUP SHALL last HALFDIV clks with sclk=0, then assert sclk=1 and enter HIGH.
REQ-018 On entry to HIGH, the block SHALL shift miso into the LSB of the rx shift register (left shift) and increment the bit counter.
REQ-019 HIGH SHALL last HALFDIV clks, then drive sclk=0.
- If bit counter < WIDTH: shift tx left, drive mosi with the next bit, enter LOW.
- If bit counter = WIDTH: enter TRAIL.
REQ-020 LOW SHALL last HALFDIV clks with mosi stable, then assert sclk=1 and enter HIGH.
REQ-021 TRAIL SHALL last HALFDIV clks with sclk=0 and cs_n=0. The next clk SHALL:
- drive cs_n=1;
- load rxData;
- pulse done=1;
- drive ready=1;
- enter IDLE.
REQ-022 Each transfer SHALL produce exactly WIDTH sclk rising edges.
REQ-023 cs_n SHALL stay low for exactly (2*WIDTH+1)*HALFDIV clks.
REQ-024 start while ready=0 SHALL be ignored, with no queuing.
REQ-025 txData changes after acceptance SHALL NOT affect the transfer in progress.
REQ-026 A start on the done cycle SHALL be accepted, since ready=1 then. The next transfer begins the following clk with a minimum cs_n-high gap of 1 clk.
REQ-027 HALFDIV=1 SHALL work: sclk period of 2 clks, cs_n low for 2*WIDTH+1 clks.
REQ-028 Half-period counter width SHALL be clog2(HALFDIV)+1, and it SHALL reset to 0 on every state change.
REQ-029 rxData SHALL NOT change except on the done cycle.

Reset
REQ-030 While rst_n=0, independent of clk, the block SHALL force:
- state=IDLE;
- cs_n=1, sclk=0, mosi=0;
- done=0, ready=1;
- rxData=0;
- tx/rx shift registers and all counters to 0.
REQ-031 Reset mid-transfer SHALL immediately raise cs_n and lower sclk with no done pulse. Partial rx data SHALL be discarded.
REQ-032 After rst_n rises, the first start SHALL be acceptable on the first clk edge.

Verification (WIDTH=8, HALFDIV=2 unless stated)
REQ-033 Loopback: miso tied to mosi, txData=0xA5, start pulse ->
- mosi sequence sampled at sclk rises is 1,0,1,0,0,1,0,1;
- cs_n low for 34 clks;
- 8 sclk rises;
- rxData=0xA5 with a single done pulse.
REQ-034 miso=1 constant, txData=0x00 -> mosi=0 throughout, rxData=0xFF.
REQ-035 txData=0x3C, start held high for the whole transfer with txData changed to 0xFF mid-transfer ->
- only 0x3C is shifted;
- a second transfer starts the clk after done.
REQ-036 rst_n pulsed low after the 4th sclk rise ->
- cs_n=1, sclk=0 within the same clk;
- done never pulses;
- rxData=0x00;
- next transfer of 0x81 in loopback returns 0x81.
REQ-037 HALFDIV=1, txData=0x5A loopback -> cs_n low for 17 clks, sclk period 2 clks, rxData=0x5A.
